// File: rtl/dispatch_unit_multi.sv
// dispatch_unit_multi
//   Multi-channel dispatch stage between the reservation station and the
//   function units. Channel k serves function-unit type k. Each channel owns
//   a round-robin arbiter over the RS entries and a single registered output
//   slot with a valid/ready handshake (EMPTY when outValid=0, FULL when 1).
//
// Optional build macro:
//   DISPATCH_PERF_CNT_EN  adds per-channel 32-bit dispCnt (loads) and
//                         bpCnt (cycles held under back-pressure) outputs.
//
// Ports:
//   clk, rstn (sync, active-low), flush (sync)
//   opValid/opReady/funcUnitType/opIn/ra/rb/rc/rat/rbt/rct/imm/rd/rdt/rdValid
//                 per-entry RS contents
//   dispatchAck   one-hot per granted entry, combinational
//   outValid/outReady            per-channel handshake
//   outFuncCode..outDstType/outRid  per-channel registered payload
//   dispCnt/bpCnt                per-channel counters (macro only)
//
// Type widths: FuncUnitType_t=FU_W, FuncCode_t=FC_W, VRegIdx_t=VR_W,
// Word_t=WORD_W, RsvID_t=RID_W.

`ifndef RSV_CAPACITY
`define RSV_CAPACITY 8
`endif

module dispatch_unit_multi #(
  parameter int unsigned RSV_CAPACITY = `RSV_CAPACITY,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned FU_W         = 3,
  parameter int unsigned FC_W         = 6,
  parameter int unsigned VR_W         = 6,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned RID_W        = (RSV_CAPACITY > 1) ? $clog2(RSV_CAPACITY) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                flush,
  input  logic [RSV_CAPACITY-1:0]             opValid,
  input  logic [RSV_CAPACITY-1:0]             opReady,
  input  logic [RSV_CAPACITY-1:0][FU_W-1:0]   funcUnitType,
  input  logic [RSV_CAPACITY-1:0][FC_W-1:0]   opIn,
  input  logic [RSV_CAPACITY-1:0][VR_W-1:0]   ra,
  input  logic [RSV_CAPACITY-1:0][VR_W-1:0]   rb,
  input  logic [RSV_CAPACITY-1:0][VR_W-1:0]   rc,
  input  logic [RSV_CAPACITY-1:0]             rat,
  input  logic [RSV_CAPACITY-1:0]             rbt,
  input  logic [RSV_CAPACITY-1:0]             rct,
  input  logic [RSV_CAPACITY-1:0][WORD_W-1:0] imm,
  input  logic [RSV_CAPACITY-1:0][VR_W-1:0]   rd,
  input  logic [RSV_CAPACITY-1:0]             rdt,
  input  logic [RSV_CAPACITY-1:0]             rdValid,
  output logic [RSV_CAPACITY-1:0]             dispatchAck,
  output logic [NUM_CH-1:0]                   outValid,
  input  logic [NUM_CH-1:0]                   outReady,
  output logic [NUM_CH-1:0][FC_W-1:0]         outFuncCode,
  output logic [NUM_CH-1:0][VR_W-1:0]         outA,
  output logic [NUM_CH-1:0][VR_W-1:0]         outB,
  output logic [NUM_CH-1:0][VR_W-1:0]         outC,
  output logic [NUM_CH-1:0]                   outAt,
  output logic [NUM_CH-1:0]                   outBt,
  output logic [NUM_CH-1:0]                   outCt,
  output logic [NUM_CH-1:0][WORD_W-1:0]       outImm,
  output logic [NUM_CH-1:0]                   outDstValid,
  output logic [NUM_CH-1:0][VR_W-1:0]         outDst,
  output logic [NUM_CH-1:0]                   outDstType,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [NUM_CH-1:0][31:0]             dispCnt,
  output logic [NUM_CH-1:0][31:0]             bpCnt,
`endif
  output logic [NUM_CH-1:0][RID_W-1:0]        outRid
);

  logic [NUM_CH-1:0][RID_W-1:0] ptr;
  logic [NUM_CH-1:0][RID_W-1:0] gnt;
  logic [NUM_CH-1:0]            ld;
  logic                         found;
  int unsigned                  j;
  logic [RID_W-1:0]             idx;

  // Per channel: scan entries starting at ptr[k], wrapping, and take the
  // first eligible one. The load is then gated by slot availability, flush
  // and reset so that dispatchAck never fires unless the op is captured.
  always_comb begin
    ld          = '0;
    gnt         = '0;
    dispatchAck = '0;
    found       = 1'b0;
    j           = 0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      found = 1'b0;
      for (int unsigned off = 0; off < RSV_CAPACITY; off++) begin
        j = 32'(ptr[k]) + off;
        if (j >= RSV_CAPACITY) j = j - RSV_CAPACITY;
        idx = RID_W'(j);
        if (!found && opValid[idx] && opReady[idx] &&
            (32'(funcUnitType[idx]) == k)) begin
          found  = 1'b1;
          gnt[k] = idx;
        end
      end
      ld[k] = found && rstn && !flush && (!outValid[k] || outReady[k]);
      if (ld[k]) dispatchAck[gnt[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outValid    <= '0;
      ptr         <= '0;
      outFuncCode <= '0;
      outA        <= '0;
      outB        <= '0;
      outC        <= '0;
      outAt       <= '0;
      outBt       <= '0;
      outCt       <= '0;
      outImm      <= '0;
      outDstValid <= '0;
      outDst      <= '0;
      outDstType  <= '0;
      outRid      <= '0;
`ifdef DISPATCH_PERF_CNT_EN
      dispCnt     <= '0;
      bpCnt       <= '0;
`endif
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (flush) begin
          outValid[k] <= 1'b0;
        end else if (ld[k]) begin
          outValid[k]    <= 1'b1;
          outFuncCode[k] <= opIn[gnt[k]];
          outA[k]        <= ra[gnt[k]];
          outB[k]        <= rb[gnt[k]];
          outC[k]        <= rc[gnt[k]];
          outAt[k]       <= rat[gnt[k]];
          outBt[k]       <= rbt[gnt[k]];
          outCt[k]       <= rct[gnt[k]];
          outImm[k]      <= imm[gnt[k]];
          outDstValid[k] <= rdValid[gnt[k]];
          outDst[k]      <= rd[gnt[k]];
          outDstType[k]  <= rdt[gnt[k]];
          outRid[k]      <= gnt[k];
          ptr[k]         <= (gnt[k] == RID_W'(RSV_CAPACITY - 1)) ? '0 : gnt[k] + RID_W'(1);
        end else if (outReady[k]) begin
          outValid[k] <= 1'b0;
        end
`ifdef DISPATCH_PERF_CNT_EN
        dispCnt[k] <= dispCnt[k] + 32'(ld[k]);
        bpCnt[k]   <= bpCnt[k] + 32'(outValid[k] & ~outReady[k]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dispatch_unit_multi.sv
module tb_dispatch_unit_multi;
  localparam int N = 8;
  localparam int C = 4;
  typedef logic [69:0] pay_t;

  logic clk, rstn, flush;
  logic [N-1:0] opValid, opReady, rat, rbt, rct, rdt, rdValid, dispatchAck;
  logic [N-1:0][2:0]  funcUnitType;
  logic [N-1:0][5:0]  opIn, ra, rb, rc, rd;
  logic [N-1:0][31:0] imm;
  logic [C-1:0] outValid, outReady, outAt, outBt, outCt, outDstValid, outDstType;
  logic [C-1:0][5:0]  outFuncCode, outA, outB, outC, outDst;
  logic [C-1:0][31:0] outImm;
  logic [C-1:0][2:0]  outRid;
`ifdef DISPATCH_PERF_CNT_EN
  logic [C-1:0][31:0] dispCnt, bpCnt;
`endif

  dispatch_unit_multi #(.RSV_CAPACITY(N), .NUM_CH(C)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .opValid(opValid), .opReady(opReady), .funcUnitType(funcUnitType),
    .opIn(opIn), .ra(ra), .rb(rb), .rc(rc), .rat(rat), .rbt(rbt), .rct(rct),
    .imm(imm), .rd(rd), .rdt(rdt), .rdValid(rdValid),
    .dispatchAck(dispatchAck), .outValid(outValid), .outReady(outReady),
    .outFuncCode(outFuncCode), .outA(outA), .outB(outB), .outC(outC),
    .outAt(outAt), .outBt(outBt), .outCt(outCt), .outImm(outImm),
    .outDstValid(outDstValid), .outDst(outDst), .outDstType(outDstType),
`ifdef DISPATCH_PERF_CNT_EN
    .dispCnt(dispCnt), .bpCnt(bpCnt),
`endif
    .outRid(outRid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  pay_t        q[C][$];
  int unsigned mptr[C];
  bit          pld[C];
  int          pgnt[C];
  logic [N-1:0] pack;
  logic [31:0] mdisp[C], mbp[C];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pay_t pay_of(input int i);
    return {opIn[i], ra[i], rb[i], rc[i], rat[i], rbt[i], rct[i], imm[i],
            rdValid[i], rd[i], rdt[i], 3'(i)};
  endfunction

  function automatic pay_t dut_pay(input int k);
    return {outFuncCode[k], outA[k], outB[k], outC[k], outAt[k], outBt[k], outCt[k],
            outImm[k], outDstValid[k], outDst[k], outDstType[k], outRid[k]};
  endfunction

  task automatic fill_entry(input int i, input int typ);
    opValid[i] = 1'b1;
    funcUnitType[i] = 3'(typ);
    opIn[i] = 6'($urandom); ra[i] = 6'($urandom); rb[i] = 6'($urandom); rc[i] = 6'($urandom);
    rat[i] = 1'($urandom); rbt[i] = 1'($urandom); rct[i] = 1'($urandom);
    imm[i] = $urandom; rd[i] = 6'($urandom); rdt[i] = 1'($urandom); rdValid[i] = 1'($urandom);
  endtask

  // Prediction: the winner for channel k is the eligible entry nearest to
  // the pointer going upward with wraparound, if the channel can accept.
  task automatic predict();
    pack = '0;
    for (int k = 0; k < C; k++) begin
      int bestd;
      pld[k] = 1'b0;
      pgnt[k] = -1;
      bestd = N;
      if (rstn && !flush && (q[k].size() == 0 || outReady[k])) begin
        for (int i = 0; i < N; i++) begin
          if (opValid[i] && opReady[i] && int'(funcUnitType[i]) == k) begin
            int d;
            d = (i + N - int'(mptr[k])) % N;
            if (d < bestd) begin bestd = d; pgnt[k] = i; end
          end
        end
      end
      if (pgnt[k] >= 0) begin
        pld[k] = 1'b1;
        pack[pgnt[k]] = 1'b1;
      end
    end
    chk("ack", dispatchAck, pack);
`ifdef DISPATCH_PERF_CNT_EN
    for (int k = 0; k < C; k++) begin
      chk($sformatf("dispCnt_ch%0d", k), dispCnt[k], mdisp[k]);
      chk($sformatf("bpCnt_ch%0d", k), bpCnt[k], mbp[k]);
    end
`endif
  endtask

  task automatic commit();
    for (int k = 0; k < C; k++) begin
      if (!rstn) begin
        q[k].delete();
        mptr[k] = 0; mdisp[k] = 0; mbp[k] = 0;
      end else begin
        if (q[k].size() != 0 && !outReady[k]) mbp[k]++;
        if (flush) q[k].delete();
        else if (pld[k]) begin
          q[k].push_back(pay_of(pgnt[k]));
          mptr[k] = (pgnt[k] + 1) % N;
          mdisp[k]++;
        end
      end
    end
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (pack[i]) opValid[i] = 1'b0;
      else if (!opValid[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          fill_entry(i, $urandom_range(0, 5));
          opReady[i] = 1'($urandom);
        end
      end else if (funcUnitType[i] >= 3'(C) && $urandom_range(0, 3) == 0) opValid[i] = 1'b0;
      else if (!opReady[i]) opReady[i] = ($urandom_range(0, 2) == 0);
    end
    outReady = 4'($urandom) | 4'($urandom);
    flush = ($urandom_range(0, 39) == 0);
    pack = '0;
  endtask

  // Monitor: compares whatever each channel presents against the oldest
  // expected op, retiring it on a handshake.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      for (int k = 0; k < C; k++) begin
        chk($sformatf("valid_ch%0d", k), outValid[k], q[k].size() != 0);
        if (outValid[k] && q[k].size() != 0) begin
          chk($sformatf("payload_ch%0d", k), dut_pay(k), q[k][0]);
          if (outReady[k]) void'(q[k].pop_front());
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; outReady = '1;
    opValid = '0; opReady = '1; pack = '0;
    funcUnitType = '0; opIn = '0; ra = '0; rb = '0; rc = '0; rat = '0; rbt = '0;
    rct = '0; imm = '0; rd = '0; rdt = '0; rdValid = '0;
    for (int k = 0; k < C; k++) begin mptr[k] = 0; mdisp[k] = 0; mbp[k] = 0; end
    for (int i = 0; i < N; i++) fill_entry(i, i % C);

    repeat (2) begin
      @(negedge clk);
      chk("reset_valid", outValid, 0);
      chk("reset_ack", dispatchAck, 0);
      for (int k = 0; k < C; k++) chk($sformatf("reset_payload_ch%0d", k), dut_pay(k), 0);
      @(posedge clk);
      commit();
    end

    #1 rstn = 1'b1;
    @(negedge clk);
    predict();
    chk("first_grant_lowest", dispatchAck, 8'h0F);
    @(posedge clk);
    commit();

    #1;
    opValid = '0; opReady = '1;
    fill_entry(2, 0); fill_entry(5, 1); fill_entry(7, 3);
    @(negedge clk);
    predict();
    chk("parallel_ack", dispatchAck, 8'hA4);
    @(posedge clk);
    commit();

    for (int it = 0; it < 3000; it++) begin
      #1;
      rstn = !(it == 1500 || it == 1501);
      drive_random();
      @(negedge clk);
      predict();
      @(posedge clk);
      commit();
    end
    #1 flush = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
